rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 13 +
 rtl/rom_arbiter_if.sv | 15 +
 rtl/rom_arb_pick.sv | 26 ++
 rtl/rom_arbiter.sv | 76 +++++++
 tb/tb_rom_arbiter.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the ROM arbiter.
package rom_arb_pkg;
    localparam int NREQ_MAX = 4;
    localparam int IDX_W    = 2;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [NREQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++)
            if (oh[i]) idx = IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: request/address in, grant and read data out.
interface rom_arbiter_if #(
    parameter int DW   = 8,
    parameter int AW   = 14,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;

    modport master (output req, addr, input ack, rd_valid, rd_data);
    modport slave  (input req, addr, output ack, rd_valid, rd_data);
endinterface

// File: rtl/rom_arb_pick.sv
// Winner selection: first requester found searching upward from start, wrapping at NREQ.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++)
            for (int j = 0; j < NREQ; j++)
                if (!found && req[j] && j == (int'(start) + k) % NREQ) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
    end

    assign idx = oh2idx(NREQ_MAX'(gnt));
endmodule

// File: rtl/rom_arbiter.sv
// Single-port ROM arbiter for NREQ requesters, one read per cycle, 1-cycle read latency.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed lowest-index priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 14,
    parameter int NREQ = 3
) (
    input  logic          clock,
    input  logic          reset,
    rom_arbiter_if.slave  bus,
    output logic          rom_ce,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_d
);
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] win_q;
    logic             vld_q;
    logic [DW-1:0]    hold;

    rom_arb_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .start (start),
        .gnt   (gnt),
        .idx   (idx)
    );

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (|gnt)
            ptr <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    assign bus.ack = reset ? '0 : gnt;
    assign rom_ce  = |bus.ack;

    always_comb begin
        rom_a = '0;
        for (int i = 0; i < NREQ; i++)
            if (bus.ack[i]) rom_a = bus.addr[i*AW +: AW];
    end

    // A read issued just before reset is dropped by gating the registered valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= 1'b0;
            win_q <= '0;
            hold  <= '0;
        end else begin
            vld_q <= |gnt;
            win_q <= idx;
            if (vld_q) hold <= rom_d;
        end
    end

    always_comb begin
        bus.rd_valid = '0;
        for (int i = 0; i < NREQ; i++)
            bus.rd_valid[i] = vld_q && !reset && (win_q == IDX_W'(i));
    end

    // ROM data arrives in the valid cycle itself, so it is passed through, then held.
    assign bus.rd_data = (vld_q && !reset) ? rom_d : hold;
endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: grants checked in-cycle, reads checked one cycle later.
module tb_rom_arbiter;
    localparam int DW   = 8;
    localparam int AW   = 14;
    localparam int NREQ = 3;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rom_ce;
    logic [AW-1:0] rom_a;
    logic [DW-1:0] rom_d = '0;

    rom_arbiter_if #(.DW(DW), .AW(AW), .NREQ(NREQ)) bus ();

    rom_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .rom_ce (rom_ce),
        .rom_a  (rom_a),
        .rom_d  (rom_d)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return DW'(a ^ (a >> 6) ^ 14'h005A);
    endfunction

    always @(posedge clock)
        if (rom_ce) rom_d <= romf(rom_a);

    exp_t          sbq[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            ptr_m   = 0;
    logic [DW-1:0] last_m  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_m(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ*AW-1:0] pack(input logic [AW-1:0] a0, a1, a2);
        return {a2, a1, a0};
    endfunction

    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, input logic rst);
        int              w;
        exp_t            e;
        logic [NREQ-1:0] exp_ack;
        logic [AW-1:0]   exp_a;
        bus.req  = r;
        bus.addr = a;
        reset    = rst;
        @(negedge clock);
        w       = rst ? -1 : pick_m(r, ptr_m);
        exp_ack = (w < 0) ? '0 : NREQ'(1) << w;
        exp_a   = (w < 0) ? '0 : a[w*AW +: AW];
        check("ack", 32'(bus.ack), 32'(exp_ack));
        check("rom_ce", 32'(rom_ce), 32'(w >= 0));
        check("rom_a", 32'(rom_a), 32'(exp_a));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!rst) begin
                check("rd_valid", 32'(bus.rd_valid), 32'(NREQ'(1) << e.idx));
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                last_m = e.data;
            end else begin
                check("rd_valid_rst", 32'(bus.rd_valid), 32'(0));
            end
        end else begin
            check("rd_valid_idle", 32'(bus.rd_valid), 32'(0));
            if (!rst) check("rd_data_hold", 32'(bus.rd_data), 32'(last_m));
        end
        if (w >= 0) begin
            e.idx  = w;
            e.data = romf(exp_a);
            sbq.push_back(e);
`ifdef ROM_ARB_ROUND_ROBIN_EN
            ptr_m = (w + 1) % NREQ;
`endif
        end
        if (rst) begin
            last_m = '0;
            ptr_m  = 0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.req  = '0;
        bus.addr = '0;
        @(posedge clock);
        #1;
        // reset: grants forced off even with every requester active
        step(3'b111, pack(14'h0001, 14'h0002, 14'h0003), 1'b1);
        step(3'b111, pack(14'h0001, 14'h0002, 14'h0003), 1'b1);
        step(3'b000, '0, 1'b0);
        // single request
        step(3'b001, pack(14'h0123, 14'h0000, 14'h0000), 1'b0);
        step(3'b000, '0, 1'b0);
        // contention
        repeat (6) step(3'b111, pack(14'h0100, 14'h0101, 14'h0102), 1'b0);
        step(3'b000, '0, 1'b0);
        // back-to-back streaming from requester 1
        step(3'b010, pack(14'h0000, 14'h0010, 14'h0000), 1'b0);
        step(3'b010, pack(14'h0000, 14'h0011, 14'h0000), 1'b0);
        step(3'b010, pack(14'h0000, 14'h0012, 14'h0000), 1'b0);
        step(3'b000, '0, 1'b0);
        // reset the cycle after a grant: that read never completes, pointer restarts at 0
        step(3'b010, pack(14'h0000, 14'h0200, 14'h0000), 1'b0);
        step(3'b000, '0, 1'b1);
        step(3'b000, '0, 1'b0);
        step(3'b111, pack(14'h0300, 14'h0301, 14'h0302), 1'b0);
        step(3'b000, '0, 1'b0);
        // idle after a read at the top address: data must hold
        step(3'b100, pack(14'h0000, 14'h0000, 14'h3FFF), 1'b0);
        repeat (10) step(3'b000, '0, 1'b0);
        // random traffic with occasional reset
        repeat (60)
            step(NREQ'($urandom_range(0, 7)),
                 pack(AW'($urandom), AW'($urandom), AW'($urandom)),
                 $urandom_range(0, 15) == 0);
        step(3'b000, '0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
